// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// valid and its payload are held until that edge, and ready never depends on valid.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, a_in, b_in, c_in, done_ready,
        input  start_ready, sum_out, c_out, ovf, done_valid, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, c_in, done_ready,
        output start_ready, sum_out, c_out, ovf, done_valid, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB first with a registered carry.
// Result, carry-out and signed overflow are registered and only change on entry to DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus,
    output logic [1:0]    fsm_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             carry_next;
    logic             bit_s;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             done_valid_q;
    logic             busy_q;

    always_comb begin
        bit_s      = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        sum_next   = sum_sh >> 1;
        sum_next[WIDTH-1] = bit_s;
    end

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            sum_sh       <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            sum_q        <= '0;
            c_out_q      <= 1'b0;
            ovf_q        <= 1'b0;
            done_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_sh   <= bus.a_in;
                        b_sh   <= bus.b_in;
                        carry  <= bus.c_in;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= carry_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // carry still holds the carry into the MSB on this edge
                        sum_q        <= sum_next;
                        c_out_q      <= carry_next;
                        ovf_q        <= carry ^ carry_next;
                        done_valid_q <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        done_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rst_n gating keeps start_ready low for the whole reset window
    assign bus.start_ready = rst_n & (state == IDLE);
    assign bus.sum_out     = sum_q;
    assign bus.c_out       = c_out_q;
    assign bus.ovf         = ovf_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.busy        = busy_q;
    assign fsm_state       = state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed/random checks plus exhaustive WIDTH=4 and WIDTH=1 sweeps.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] st8, st4, st1;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(4)) if4 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8), .fsm_state(st8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .fsm_state(st4));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .fsm_state(st1));

    int total = 0;
    int bad = 0;
    logic [9:0] prev8;
    logic [5:0] exp4_q[$];
    logic [2:0] exp1_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow judged by range of the signed sum.
    function automatic void ref_add(input int w, input int a, input int b, input int c,
                                    output int s, output int co, output int ov);
        int full, sa, sb, ss;
        full = a + b + c;
        s    = full % (1 << w);
        co   = full >> w;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        ss   = sa + sb + c;
        ov   = ((ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)))) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        logic [5:0] e4;
        logic [2:0] e1;
        if (rst_n && if4.done_valid && if4.done_ready) begin
            if (exp4_q.size() == 0) begin
                total++; bad++;
                $display("FAIL w4_extra: got result %0h expected none", if4.sum_out);
            end else begin
                e4 = exp4_q.pop_front();
                check("w4_result", {if4.ovf, if4.c_out, if4.sum_out}, e4);
            end
        end
        if (rst_n && if1.done_valid && if1.done_ready) begin
            if (exp1_q.size() == 0) begin
                total++; bad++;
                $display("FAIL w1_extra: got result %0h expected none", if1.sum_out);
            end else begin
                e1 = exp1_q.pop_front();
                check("w1_result", {if1.ovf, if1.c_out, if1.sum_out}, e1);
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic eco, input logic eov, input int stall);
        int n;
        int lat;
        n = 0;
        while (!if8.start_ready && n < 40) begin @(posedge clk); #1; n++; end
        check("w8_ready_wait", 32'(n < 40), 1);
        if8.a_in = a; if8.b_in = b; if8.c_in = c;
        if8.start_valid = 1'b1;
        if8.done_ready  = (stall == 0);
        @(posedge clk); #1;
        if8.start_valid = 1'b0;
        lat = 0;
        while (!if8.done_valid && lat < 40) begin
            check("w8_hold_run", {if8.ovf, if8.c_out, if8.sum_out}, prev8);
            if8.a_in = 8'($urandom); if8.b_in = 8'($urandom); if8.c_in = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", lat, 8);
        check("w8_sum", if8.sum_out, es);
        check("w8_cout", if8.c_out, eco);
        check("w8_ovf", if8.ovf, eov);
        prev8 = {eov, eco, es};
        for (int i = 0; i < stall; i++) begin
            if8.start_valid = 1'b1;
            if8.a_in = 8'($urandom); if8.b_in = 8'($urandom); if8.c_in = 1'($urandom);
            check("w8_stall_flags", {if8.done_valid, if8.busy, if8.start_ready}, 3'b110);
            check("w8_stall_hold", {if8.ovf, if8.c_out, if8.sum_out}, prev8);
            @(posedge clk); #1;
        end
        if8.done_ready = 1'b1;
        @(posedge clk); #1;
        if8.start_valid = 1'b0;
        check("w8_release", {if8.done_valid, if8.busy, if8.start_ready}, 3'b001);
        check("w8_idle_hold", {if8.ovf, if8.c_out, if8.sum_out}, prev8);
    endtask

    task automatic sweep4();
        int n, s, co, ov;
        for (int i = 0; i < 512; i++) begin
            n = 0;
            while (!if4.start_ready && n < 40) begin
                if4.done_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
                n++;
            end
            check("w4_ready_wait", 32'(n < 40), 1);
            ref_add(4, i & 15, (i >> 4) & 15, (i >> 8) & 1, s, co, ov);
            exp4_q.push_back({1'(ov), 1'(co), 4'(s)});
            if4.a_in = 4'(i); if4.b_in = 4'(i >> 4); if4.c_in = 1'(i >> 8);
            if4.start_valid = 1'b1;
            @(posedge clk); #1;
            if4.start_valid = 1'b0;
        end
        if4.done_ready = 1'b1;
        n = 0;
        while (exp4_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
        check("w4_drain", exp4_q.size(), 0);
    endtask

    task automatic sweep1();
        int n, s, co, ov;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (!if1.start_ready && n < 40) begin
                if1.done_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
                n++;
            end
            check("w1_ready_wait", 32'(n < 40), 1);
            ref_add(1, i & 1, (i >> 1) & 1, (i >> 2) & 1, s, co, ov);
            exp1_q.push_back({1'(ov), 1'(co), 1'(s)});
            if1.a_in = 1'(i); if1.b_in = 1'(i >> 1); if1.c_in = 1'(i >> 2);
            if1.start_valid = 1'b1;
            @(posedge clk); #1;
            if1.start_valid = 1'b0;
        end
        if1.done_ready = 1'b1;
        n = 0;
        while (exp1_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
        check("w1_drain", exp1_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, co, ov;
        logic [7:0] ra, rb;
        logic rc;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 5};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 2};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1};

        rst_n = 1'b0;
        if8.start_valid = 0; if8.a_in = 0; if8.b_in = 0; if8.c_in = 0; if8.done_ready = 0;
        if4.start_valid = 0; if4.a_in = 0; if4.b_in = 0; if4.c_in = 0; if4.done_ready = 0;
        if1.start_valid = 0; if1.a_in = 0; if1.b_in = 0; if1.c_in = 0; if1.done_ready = 0;
        prev8 = '0;
        #12;
        check("rst_flags8", {if8.start_ready, if8.done_valid, if8.busy}, 3'b000);
        check("rst_result8", {if8.ovf, if8.c_out, if8.sum_out}, 0);
        check("rst_state8", st8, 0);
        check("rst_ready4", if4.start_ready, 0);
        check("rst_ready1", if1.start_ready, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready8", if8.start_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].stall);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            ref_add(8, int'(ra), int'(rb), int'(rc), s, co, ov);
            run8(ra, rb, rc, 8'(s), 1'(co), 1'(ov), $urandom_range(0, 3));
        end

        // Abort mid-RUN: the held 0x80 result must vanish with reset, not reappear.
        run8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);
        if8.a_in = 8'h33; if8.b_in = 8'h44; if8.c_in = 1'b0;
        if8.start_valid = 1'b1;
        @(posedge clk); #1;
        if8.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_run_busy", {if8.busy, if8.done_valid}, 2'b10);
        check("mid_run_hold", if8.sum_out, 8'h80);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {if8.start_ready, if8.done_valid, if8.busy}, 3'b000);
        check("mid_rst_result", {if8.ovf, if8.c_out, if8.sum_out}, 0);
        check("mid_rst_state", st8, 0);
        #2;
        rst_n = 1'b1;
        prev8 = '0;
        @(posedge clk); #1;
        check("after_rst_flags", {if8.start_ready, if8.done_valid, if8.busy}, 3'b100);
        run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

        sweep4();
        sweep1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It is the addition counterpart of the team's combinational full_subtractor.
- One full-adder cell is reused across WIDTH cycles, LSB first, with a registered carry.
- A valid/ready handshake accepts operands and returns the result with carry-out and signed overflow.
- Used where area matters more than latency, e.g. accumulate/checksum paths.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands present on a_in/b_in/c_in
- start_ready  output  1  block can accept operands (IDLE only)
- a_in  input  WIDTH  operand A, sampled only on accept
- b_in  input  WIDTH  operand B, sampled only on accept
- c_in  input  1  carry-in, sampled only on accept
- sum_out  output  WIDTH  result A+B+c_in mod 2^WIDTH
- c_out  output  1  unsigned carry out of MSB
- ovf  output  1  signed two's-complement overflow
- done_valid  output  1  result valid
- done_ready  input  1  consumer accepts result
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. All registers and outputs are 0; start_ready=0 only while rst_n is low. Reset asserted mid-RUN or mid-DONE aborts the operation immediately; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1, busy=0, done_valid=0.
  - Accept happens on a rising edge with start_valid=1. On accept: latch a_in→shift reg A, b_in→shift reg B, c_in→carry, bit counter=0; go to RUN.
- RUN: one bit per cycle.
  - Per cycle: s = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry); A and B shift right; s shifts into the MSB of the internal sum register; counter increments.
  - On the edge that processes bit WIDTH-1: record the carry into the MSB (carry before update) and go to DONE. On that same edge load sum_out, c_out and ovf.
  - Counter width is $clog2(WIDTH+1).
- DONE:
  - done_valid=1, busy=1, start_ready=0.
  - The edge with done_ready=1 returns the block to IDLE.
  - If done_ready is already high on entry, DONE lasts exactly 1 cycle.
- Latency: done_valid rises WIDTH clock edges after the accept edge. Throughput is one operation per WIDTH+2 cycles minimum (accept, WIDTH bits, DONE).
- Output holding:
  - sum_out, c_out and ovf are registered and change only when DONE is entered.
  - They hold the last completed result through IDLE and the next RUN.
  - They are never shown mid-shift.
- Result flags:
  - ovf = carry_into_MSB XOR c_out.
  - For WIDTH=1, carry_into_MSB = c_in.
- Input handling:
  - start_valid in RUN/DONE is ignored (start_ready=0), with no queuing.
  - Changes to a_in/b_in/c_in after accept do not affect the result.
- done_ready outside DONE has no effect.
- No combinational path from any input to any output except the asynchronous rst_n.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, done_ready=1 → done_valid rises 8 edges after accept; sum=0x96, c_out=0, ovf=1; DONE lasts 1 cycle, then start_ready=1.
- a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, ovf=0. Then a=0x7F, b=0x00, c_in=1 → sum=0x80, c_out=0, ovf=1. Run these back-to-back; second accept occurs the cycle start_ready returns.
- Backpressure: result 0x96 with done_ready=0 for 5 cycles → done_valid, sum_out, c_out and ovf stay stable. start_valid=1 with new operands in that window is ignored. Raise done_ready → IDLE, then the new operands are accepted.
- Operand change: a_in/b_in/c_in toggled every cycle during RUN → result equals the values latched on the accept edge.
- Reset mid-RUN: rst_n low after 3 bits processed → all outputs 0 immediately, state IDLE. Release reset, then run 0x10+0x20 → sum=0x30, c_out=0, ovf=0.
- Exhaustive sweeps:
  - WIDTH=4: all 512 combinations of a, b and c_in, with random done_ready stalls. Check {c_out,sum} = a+b+c_in and ovf against the signed reference.
  - WIDTH=1: all 8 combinations, checked the same way.
